// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: shared widths, ALU/forward encodings and the ID/EX register layout.
package id_ex_operand_stage_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 3;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND  = 3'd0,
        ALU_XOR  = 3'd1,
        ALU_SLL  = 3'd2,
        ALU_ADD  = 3'd3,
        ALU_SUB  = 3'd4,
        ALU_MUL  = 3'd5,
        ALU_ADDI = 3'd6,
        ALU_SRAI = 3'd7
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [CTRL_W-1:0]  alu_ctrl;
        logic               alu_src;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               memto_reg;
    } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_forward_mux.sv
// forward_mux: picks the freshest value for one source register; EX/MEM beats MEM/WB, x0 never forwards.
module forward_mux
    import id_ex_operand_stage_pkg::*;
(
    input  logic [RADDR_W-1:0] rs_i,
    input  logic [XLEN-1:0]    rf_data_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic               exmem_we_i,
    input  logic [XLEN-1:0]    exmem_data_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic               memwb_we_i,
    input  logic [XLEN-1:0]    memwb_data_i,
    output logic [XLEN-1:0]    data_o
);

    fwd_sel_e sel;

    always_comb begin
        sel    = (exmem_we_i && exmem_rd_i != '0 && exmem_rd_i == rs_i) ? FWD_EXMEM :
                 (memwb_we_i && memwb_rd_i != '0 && memwb_rd_i == rs_i) ? FWD_MEMWB : FWD_RF;
        data_o = (sel == FWD_EXMEM) ? exmem_data_i :
                 (sel == FWD_MEMWB) ? memwb_data_i : rf_data_i;
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with EX-side operand forwarding feeding the ALU.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [RADDR_W-1:0] id_rs1_i,
    input  logic [RADDR_W-1:0] id_rs2_i,
    input  logic [RADDR_W-1:0] id_rd_i,
    input  logic [XLEN-1:0]    id_rs1_data_i,
    input  logic [XLEN-1:0]    id_rs2_data_i,
    input  logic [XLEN-1:0]    id_imm_i,
    input  logic [CTRL_W-1:0]  id_ALUCtrl_i,
    input  logic               id_ALUSrc_i,
    input  logic               id_RegWrite_i,
    input  logic               id_MemRead_i,
    input  logic               id_MemWrite_i,
    input  logic               id_MemtoReg_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic               exmem_RegWrite_i,
    input  logic [XLEN-1:0]    exmem_result_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic               memwb_RegWrite_i,
    input  logic [XLEN-1:0]    memwb_wdata_i,
    output logic [XLEN-1:0]    data1_o,
    output logic [XLEN-1:0]    data2_o,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic [XLEN-1:0]    store_data_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic               valid_o,
    output logic               RegWrite_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               MemtoReg_o
);

    id_ex_t          stage_q, stage_d, id_stage;
    logic [XLEN-1:0] fwd_a, fwd_b;

    always_comb begin
        id_stage = '{valid: id_valid_i, rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i,
                     rs1_data: id_rs1_data_i, rs2_data: id_rs2_data_i, imm: id_imm_i,
                     alu_ctrl: id_ALUCtrl_i, alu_src: id_ALUSrc_i, reg_write: id_RegWrite_i,
                     mem_read: id_MemRead_i, mem_write: id_MemWrite_i, memto_reg: id_MemtoReg_i};
        // a taken branch kills the incoming instruction even if the pipe is stalled
        stage_d  = flush_i ? id_ex_t'('0) : stall_i ? stage_q : id_stage;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    forward_mux u_fwd_a (
        .rs_i(stage_q.rs1), .rf_data_i(stage_q.rs1_data),
        .exmem_rd_i(exmem_rd_i), .exmem_we_i(exmem_RegWrite_i), .exmem_data_i(exmem_result_i),
        .memwb_rd_i(memwb_rd_i), .memwb_we_i(memwb_RegWrite_i), .memwb_data_i(memwb_wdata_i),
        .data_o(fwd_a)
    );

    forward_mux u_fwd_b (
        .rs_i(stage_q.rs2), .rf_data_i(stage_q.rs2_data),
        .exmem_rd_i(exmem_rd_i), .exmem_we_i(exmem_RegWrite_i), .exmem_data_i(exmem_result_i),
        .memwb_rd_i(memwb_rd_i), .memwb_we_i(memwb_RegWrite_i), .memwb_data_i(memwb_wdata_i),
        .data_o(fwd_b)
    );

    assign data1_o      = fwd_a;
    assign data2_o      = stage_q.alu_src ? stage_q.imm : fwd_b;
    assign store_data_o = fwd_b;
    assign ALUCtrl_o    = stage_q.alu_ctrl;
    assign rd_o         = stage_q.rd;
    assign valid_o      = stage_q.valid;
    assign RegWrite_o   = stage_q.reg_write & stage_q.valid;
    assign MemRead_o    = stage_q.mem_read & stage_q.valid;
    assign MemWrite_o   = stage_q.mem_write & stage_q.valid;
    assign MemtoReg_o   = stage_q.memto_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: vector table, hand-written stall/flush/reset sequences and a randomized model check.
module tb_id_ex_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, exmem_rd_i, memwb_rd_i, rd_o;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, exmem_result_i, memwb_wdata_i;
    logic [2:0]  id_ALUCtrl_i, ALUCtrl_o;
    logic        id_ALUSrc_i, id_RegWrite_i, id_MemRead_i, id_MemWrite_i, id_MemtoReg_i;
    logic        exmem_RegWrite_i, memwb_RegWrite_i;
    logic [31:0] data1_o, data2_o, store_data_o;
    logic        valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o;

    always #5 clk_i = ~clk_i;

    id_ex_operand_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_ALUCtrl_i(id_ALUCtrl_i), .id_ALUSrc_i(id_ALUSrc_i), .id_RegWrite_i(id_RegWrite_i),
        .id_MemRead_i(id_MemRead_i), .id_MemWrite_i(id_MemWrite_i), .id_MemtoReg_i(id_MemtoReg_i),
        .exmem_rd_i(exmem_rd_i), .exmem_RegWrite_i(exmem_RegWrite_i), .exmem_result_i(exmem_result_i),
        .memwb_rd_i(memwb_rd_i), .memwb_RegWrite_i(memwb_RegWrite_i), .memwb_wdata_i(memwb_wdata_i),
        .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o), .store_data_o(store_data_o),
        .rd_o(rd_o), .valid_o(valid_o), .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the instruction the stage should currently hold
    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] a, b, imm;
        logic [2:0]  ctrl;
        logic        src, rw, mr, mw, m2r;
    } instr_t;

    instr_t m;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i || flush_i) m <= '{default: 0};
        else if (!stall_i)
            m <= '{id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
                   id_ALUCtrl_i, id_ALUSrc_i, id_RegWrite_i, id_MemRead_i, id_MemWrite_i, id_MemtoReg_i};
    end

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return rf;
        if (exmem_RegWrite_i && exmem_rd_i == rs) return exmem_result_i;
        if (memwb_RegWrite_i && memwb_rd_i == rs) return memwb_wdata_i;
        return rf;
    endfunction

    task automatic check_model();
        chk("rand_data1", data1_o, fwd(m.rs1, m.a));
        chk("rand_data2", data2_o, m.src ? m.imm : fwd(m.rs2, m.b));
        chk("rand_store", store_data_o, fwd(m.rs2, m.b));
        chk("rand_ctrl", ALUCtrl_o, m.ctrl);
        chk("rand_rd", rd_o, m.rd);
        chk("rand_valid", valid_o, m.v);
        chk("rand_RegWrite", RegWrite_o, m.rw & m.v);
        chk("rand_MemRead", MemRead_o, m.mr & m.v);
        chk("rand_MemWrite", MemWrite_o, m.mw & m.v);
        chk("rand_MemtoReg", MemtoReg_o, m.m2r);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, rs2, rd, input logic [31:0] a, b, imm,
                          input logic [2:0] ctrl, input logic src, rw, mr, mw, m2r);
        id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_rs1_data_i = a; id_rs2_data_i = b; id_imm_i = imm; id_ALUCtrl_i = ctrl;
        id_ALUSrc_i = src; id_RegWrite_i = rw; id_MemRead_i = mr; id_MemWrite_i = mw; id_MemtoReg_i = m2r;
    endtask

    task automatic set_byp(input logic [4:0] exrd, input logic exwe, input logic [31:0] exres,
                           input logic [4:0] wbrd, input logic wbwe, input logic [31:0] wbd);
        exmem_rd_i = exrd; exmem_RegWrite_i = exwe; exmem_result_i = exres;
        memwb_rd_i = wbrd; memwb_RegWrite_i = wbwe; memwb_wdata_i = wbd;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] a, b, imm;
        logic [2:0]  ctrl;
        logic        src;
        logic [4:0]  exrd;
        logic        exwe;
        logic [31:0] exres;
        logic [4:0]  wbrd;
        logic        wbwe;
        logic [31:0] wbd, e1, e2, es;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, 2, 32'h10, 32'h20, 32'hFFFFFFF0, 3'd6, 1, 0, 0, 0, 0, 0, 0,
                    32'h10, 32'hFFFFFFF0, 32'h20};
        vecs[1] = '{5, 3, 32'h11, 32'h33, 32'h0, 3'd3, 0, 5, 1, 32'h1234, 5, 1, 32'h5678,
                    32'h1234, 32'h33, 32'h33};
        vecs[2] = '{5, 3, 32'h11, 32'h33, 32'h0, 3'd3, 0, 5, 0, 32'h1234, 5, 1, 32'h5678,
                    32'h5678, 32'h33, 32'h33};
        vecs[3] = '{4, 0, 32'h44, 32'h0, 32'h9, 3'd0, 0, 0, 1, 32'hDEAD, 0, 1, 32'hBEEF,
                    32'h44, 32'h0, 32'h0};
        vecs[4] = '{6, 7, 32'h1, 32'h77, 32'h100, 3'd3, 1, 6, 1, 32'h66, 7, 1, 32'hAB,
                    32'h66, 32'h100, 32'hAB};
        vecs[5] = '{0, 9, 32'h0, 32'h99, 32'h5, 3'd4, 0, 9, 1, 32'hAAAA, 9, 1, 32'hBBBB,
                    32'h0, 32'hAAAA, 32'hAAAA};
        vecs[6] = '{3, 3, 32'h3, 32'h30, 32'h7, 3'd1, 0, 3, 0, 32'h9, 3, 0, 32'h8,
                    32'h3, 32'h30, 32'h30};

        rst_i = 0; stall_i = 0; flush_i = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_byp(0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_valid", valid_o, 0);
        chk("reset_data1", data1_o, 0);
        chk("reset_data2", data2_o, 0);
        chk("reset_store", store_data_o, 0);
        chk("reset_RegWrite", RegWrite_o, 0);
        @(negedge clk_i) rst_i = 1;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            set_id(1, vecs[i].rs1, vecs[i].rs2, 5'(i + 1), vecs[i].a, vecs[i].b, vecs[i].imm,
                   vecs[i].ctrl, vecs[i].src, 1, 0, 0, 0);
            set_byp(0, 0, 0, 0, 0, 0);
            @(posedge clk_i);
            #1 set_byp(vecs[i].exrd, vecs[i].exwe, vecs[i].exres, vecs[i].wbrd, vecs[i].wbwe, vecs[i].wbd);
            #1;
            chk($sformatf("vec%0d_data1", i), data1_o, vecs[i].e1);
            chk($sformatf("vec%0d_data2", i), data2_o, vecs[i].e2);
            chk($sformatf("vec%0d_store", i), store_data_o, vecs[i].es);
            chk($sformatf("vec%0d_ctrl", i), ALUCtrl_o, vecs[i].ctrl);
            chk($sformatf("vec%0d_rd", i), rd_o, i + 1);
        end

        // stall holds, forwarding still tracks, flush beats stall
        @(negedge clk_i);
        set_id(1, 1, 2, 4, 32'hA1, 32'hA2, 0, 3'd3, 0, 1, 0, 1, 0);
        set_byp(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        stall_i = 1;
        set_id(0, 8, 9, 10, 32'hFF, 32'hFE, 0, 3'd0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1;
            chk("stall_data1", data1_o, 32'hA1);
            chk("stall_valid", valid_o, 1);
            chk("stall_RegWrite", RegWrite_o, 1);
            chk("stall_rd", rd_o, 4);
        end
        set_byp(1, 1, 32'hC0DE, 0, 0, 0);
        #1 chk("stall_fwd_data1", data1_o, 32'hC0DE);
        @(negedge clk_i) flush_i = 1;
        @(posedge clk_i); #1;
        chk("flush_valid", valid_o, 0);
        chk("flush_RegWrite", RegWrite_o, 0);
        chk("flush_MemWrite", MemWrite_o, 0);
        chk("flush_data1", data1_o, 0);
        @(negedge clk_i) begin stall_i = 0; flush_i = 0; end

        // capture with id_valid_i=0: control must be gated
        set_id(0, 1, 2, 3, 1, 2, 3, 3'd5, 0, 1, 1, 1, 1);
        set_byp(0, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        chk("gate_RegWrite", RegWrite_o, 0);
        chk("gate_MemRead", MemRead_o, 0);
        chk("gate_MemWrite", MemWrite_o, 0);

        // asynchronous reset mid-cycle drops a live instruction
        @(negedge clk_i);
        set_id(1, 3, 0, 6, 32'h55, 0, 0, 3'd7, 0, 1, 1, 0, 1);
        @(posedge clk_i); #1 chk("pre_reset_valid", valid_o, 1);
        #2 rst_i = 0;
        #1;
        chk("async_valid", valid_o, 0);
        chk("async_data1", data1_o, 0);
        chk("async_RegWrite", RegWrite_o, 0);
        chk("async_MemRead", MemRead_o, 0);
        chk("async_ctrl", ALUCtrl_o, 0);
        @(negedge clk_i) rst_i = 1;

        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            set_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
                   $urandom, $urandom, $urandom, 3'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 6) == 0);
            set_byp(5'($urandom_range(0, 7)), 1'($urandom), $urandom,
                    5'($urandom_range(0, 7)), 1'($urandom), $urandom);
            @(posedge clk_i); #1;
            check_model();
            set_byp(5'($urandom_range(0, 7)), 1'($urandom), $urandom,
                    5'($urandom_range(0, 7)), 1'($urandom), $urandom);
            #1 check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
